// File: rtl/gray_codec_pipe.sv
// Two-stage valid/ready pipeline converting gray<->binary per beat.
// Optional gray-adjacency checker compiled in with GRAY_CODEC_ADJ_CHK_EN.
module gray_codec_pipe #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_mode,
    output logic         adj_err
);

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [W-1:0] bin2gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic         r_s1_valid;
    logic [W-1:0] r_s1_data;
    logic         r_s1_mode;
    logic         r_s2_valid;
    logic [W-1:0] r_s2_data;
    logic         r_s2_mode;

    logic w_s2_adv;
    logic w_s1_adv;
    logic w_accept;

    assign w_s2_adv = ~r_s2_valid | out_ready;
    assign w_s1_adv = ~r_s1_valid | w_s2_adv;
    assign in_ready = rst_n & w_s1_adv;
    assign w_accept = in_valid & in_ready;

    // Stage 1: capture the raw word and its mode on acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= {W{1'b0}};
            r_s1_mode  <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_data <= in_data;
                r_s1_mode <= mode;
            end
        end
    end

    // Stage 2: convert and hold the result until downstream takes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= {W{1'b0}};
            r_s2_mode  <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= r_s1_mode ? bin2gray(r_s1_data) : gray2bin(r_s1_data);
                r_s2_mode <= r_s1_mode;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign out_mode  = r_s2_mode;

`ifdef GRAY_CODEC_ADJ_CHK_EN
    function automatic logic is_onehot(input logic [W-1:0] x);
        return (x != {W{1'b0}}) && ((x & (x - {{(W-1){1'b0}}, 1'b1})) == {W{1'b0}});
    endfunction

    logic [W-1:0] r_hist;
    logic         r_hist_valid;
    logic         r_adj_err;

    // Successive gray-mode inputs must differ in exactly one bit; error is sticky.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hist       <= {W{1'b0}};
            r_hist_valid <= 1'b0;
            r_adj_err    <= 1'b0;
        end else if (w_accept && !mode) begin
            if (r_hist_valid && !is_onehot(in_data ^ r_hist)) begin
                r_adj_err <= 1'b1;
            end
            r_hist       <= in_data;
            r_hist_valid <= 1'b1;
        end
    end

    assign adj_err = r_adj_err;
`else
    assign adj_err = 1'b0;
`endif

endmodule

// File: doc/gray_codec_pipe.md
GRAY_CODEC_PIPE -- requirements
Module: gray_codec_pipe

Interface
REQ-001 SHALL have parameter W, default 8, meaning code word width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset is synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, meaning the upstream beat is present.
REQ-005 SHALL have port in_ready, output, 1, meaning the block accepts a beat this cycle.
REQ-006 SHALL have port in_data, input, W, meaning the input code word.
REQ-007 SHALL have port mode, input, 1, meaning per-beat conversion select: 0 = gray-to-binary, 1 = binary-to-gray.
REQ-008 SHALL have port out_valid, output, 1, meaning a result beat is present.
REQ-009 SHALL have port out_ready, input, 1, meaning downstream accepts the result beat.
REQ-010 SHALL have port out_data, output, W, meaning the converted word.
REQ-011 SHALL have port out_mode, output, 1, meaning the mode that travelled with the result beat.
REQ-012 SHALL have port adj_err, output, 1, meaning sticky gray-adjacency violation flag.

Function
REQ-013 SHALL accept a beat on a rising edge where in_valid and in_ready are both 1, capturing in_data and mode into stage 1.
REQ-014 SHALL compute the conversion between stage 1 and stage 2 and register the result, with out_mode, in stage 2.
REQ-015 SHALL perform gray-to-binary as b[W-1]=g[W-1] and b[i]=b[i+1]^g[i] for i=W-2..0.
REQ-016 SHALL perform binary-to-gray as g[W-1]=b[W-1] and g[i]=b[i+1]^b[i] for i=W-2..0.
REQ-017 SHALL have latency 2: a beat accepted at edge N appears on out_valid/out_data after edge N+1, provided it is not stalled.
REQ-018 SHALL advance stage 2 when !s2_valid || out_ready, and stage 1 when !s1_valid || stage-2-advance.
REQ-019 SHALL drive in_ready as the stage-1-advance term, combinationally, giving full throughput of one beat per cycle when out_ready=1.
REQ-020 SHALL hold out_valid, out_data and out_mode stable while out_valid=1 and out_ready=0.
REQ-021 SHALL never drop or duplicate a beat under any in_valid/out_ready pattern; at most 2 beats are in flight.
REQ-022 SHALL apply mode per beat, so mixed-mode streams convert each beat per its own captured mode.
REQ-023 SHALL treat simultaneous stage-2 drain and stage-1 refill in one cycle as legal with no bubble.

Reset
REQ-024 SHALL, on any rising edge with rst_n=0, clear s1_valid, s2_valid, out_valid, adj_err and the adjacency history valid bit.
REQ-025 SHALL drive out_data and out_mode to 0 after reset.
REQ-026 SHALL discard all in-flight beats when reset is asserted mid-operation; out_valid=0 on the cycle after the reset edge.
REQ-027 SHALL drive in_ready=0 while rst_n=0.

Configuration
REQ-028 SHALL compile the adjacency checker only when macro GRAY_CODEC_ADJ_CHK_EN is defined.
REQ-029 With GRAY_CODEC_ADJ_CHK_EN defined, the block SHALL keep the last accepted mode-0 input word plus a history-valid bit. On each accepted mode-0 beat with the history valid, it SHALL set adj_err on that edge if the XOR with the history word does not have exactly one bit set; equal words count as a violation.
REQ-030 With GRAY_CODEC_ADJ_CHK_EN defined, the first mode-0 beat after reset SHALL only load the history, mode-1 beats SHALL neither check nor update the history, and adj_err SHALL stay set until reset.
REQ-031 Without GRAY_CODEC_ADJ_CHK_EN, adj_err SHALL be tied to 0, no history state SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-032 W=4, mode=0, in_data=4'b1101, out_ready=1 SHALL produce out_data=4'b1001 and out_mode=0 two edges after acceptance.
REQ-033 W=4, mode=1, in_data=4'b1001 SHALL produce out_data=4'b1101; with W=8, mode=0, in_data=8'h80 SHALL produce 8'hFF.
REQ-034 Backpressure: with out_ready=0 for 4 cycles and 3 beats offered, the block SHALL hold 2 beats and keep in_ready=0. After out_ready=1, all 3 results SHALL emerge in order, with no loss.
REQ-035 Reset mid-stream: rst_n=0 for one edge with both stages full SHALL give out_valid=0 and adj_err=0 the next cycle; the next accepted beat SHALL take latency 2.
REQ-036 With the macro defined, mode-0 beats 8'h00, 8'h01, 8'h03 SHALL leave adj_err=0. A following 8'h00 SHALL set adj_err=1 after its acceptance edge. An interleaved mode-1 beat SHALL not affect the history. Without the macro, adj_err SHALL stay 0.
